axis_upsize_16_32: RTL and testbench

- AXI-Stream width upsizer, the inverse of the team's 32-to-16 downsizer.
- Packs RATIO consecutive narrow slave beats into one wide master beat.
- Preserves tkeep, tlast, tid, tdest and tuser semantics.
- Sits between a 16-bit producer and a 32-bit consumer; single clock domain, no FIFO, one registered output stage.

---
 rtl/axis_upsize_16_32.sv | 125 ++++++++++++
 tb/tb_axis_upsize_16_32.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_upsize_16_32.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide beat.
// Optional: define AXIS_UPSIZE_ID_FLUSH_EN to flush partial words on tid/tdest change.
module axis_upsize_16_32 #(
  parameter int S_DATA_WIDTH = 16,
  parameter int RATIO        = 2,
  parameter int ID_WIDTH     = 1,
  parameter int DEST_WIDTH   = 1,
  parameter int USER_WIDTH   = 1
) (
  input  logic                             axis_clk,
  input  logic                             axis_rst,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [S_DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [S_DATA_WIDTH/8-1:0]        s_axis_tkeep,
  input  logic                             s_axis_tlast,
  input  logic [ID_WIDTH-1:0]              s_axis_tid,
  input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [S_DATA_WIDTH*RATIO-1:0]    m_axis_tdata,
  output logic [S_DATA_WIDTH*RATIO/8-1:0]  m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [USER_WIDTH-1:0]            m_axis_tuser
);

  localparam int M  = S_DATA_WIDTH * RATIO;
  localparam int KS = S_DATA_WIDTH / 8;
  localparam int KM = M / 8;
  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [IW-1:0]         r_idx;
  logic                  r_valid;
  logic [M-1:0]          r_data;
  logic [KM-1:0]         r_keep;
  logic                  r_last;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [USER_WIDTH-1:0] r_user;

  logic                  w_free;
  logic                  w_flush;
  logic                  w_accept;
  logic                  w_done;
  logic [M-1:0]          w_data_n;
  logic [KM-1:0]         w_keep_n;
  logic [USER_WIDTH-1:0] w_user_n;

  assign w_free = !r_valid || m_axis_tready;

`ifdef AXIS_UPSIZE_ID_FLUSH_EN
  // A partial word only exists while r_valid is low, so r_id/r_dest
  // hold the ids of the word being packed.
  assign w_flush = s_axis_tvalid && (r_idx != '0) &&
                   ((s_axis_tid != r_id) || (s_axis_tdest != r_dest));
`else
  assign w_flush = 1'b0;
`endif

  assign s_axis_tready = !axis_rst && w_free && !w_flush;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_done        = w_accept &&
                         (s_axis_tlast || (r_idx == IW'(RATIO - 1)));

  always_comb begin
    w_data_n = (r_idx == '0) ? '0 : r_data;
    w_keep_n = (r_idx == '0) ? '0 : r_keep;
    w_user_n = (r_idx == '0) ? s_axis_tuser
                             : (r_user | s_axis_tuser);
    for (int i = 0; i < RATIO; i++) begin
      if (r_idx == IW'(i)) begin
        w_data_n[i*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
        w_keep_n[i*KS +: KS] = s_axis_tkeep;
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_id    <= '0;
      r_dest  <= '0;
      r_user  <= '0;
    end else begin
      if (r_valid && m_axis_tready) begin
        r_valid <= 1'b0;
      end
      if (w_flush) begin
        r_valid <= 1'b1;
        r_last  <= 1'b0;
        r_idx   <= '0;
      end else if (w_accept) begin
        r_data <= w_data_n;
        r_keep <= w_keep_n;
        r_user <= w_user_n;
        r_id   <= s_axis_tid;
        r_dest <= s_axis_tdest;
        if (w_done) begin
          r_valid <= 1'b1;
          r_last  <= s_axis_tlast;
          r_idx   <= '0;
        end else begin
          r_last  <= 1'b0;
          r_idx   <= r_idx + IW'(1);
        end
      end
    end
  end

  assign m_axis_tvalid = r_valid;
  assign m_axis_tdata  = r_data;
  assign m_axis_tkeep  = r_keep;
  assign m_axis_tlast  = r_last;
  assign m_axis_tid    = r_id;
  assign m_axis_tdest  = r_dest;
  assign m_axis_tuser  = r_user;

endmodule

// File: tb/tb_axis_upsize_16_32.sv
// Directed bench for axis_upsize_16_32 with immediate-assertion checks.
// Honours AXIS_UPSIZE_ID_FLUSH_EN for the tid-change scenario.
module tb_axis_upsize_16_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [1:0]  s_keep;
  logic        s_last;
  logic [0:0]  s_id;
  logic [0:0]  s_dest;
  logic [0:0]  s_user;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic [0:0]  m_id;
  logic [0:0]  m_dest;
  logic [0:0]  m_user;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int vcnt;
  logic rdy_ok;

  always #5 clk = ~clk;

  axis_upsize_16_32 dut (
    .axis_clk      (clk),
    .axis_rst      (rst),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tlast  (s_last),
    .s_axis_tid    (s_id),
    .s_axis_tdest  (s_dest),
    .s_axis_tuser  (s_user),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tlast  (m_last),
    .m_axis_tid    (m_id),
    .m_axis_tdest  (m_dest),
    .m_axis_tuser  (m_user)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic [1:0] k,
                      input logic l, input logic i,
                      input logic de, input logic u);
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_id    = i;
    s_dest  = de;
    s_user  = u;
  endtask

  initial begin
    rst = 1'b1; m_ready = 1'b1;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    s_id = '0; s_dest = '0; s_user = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_keep", 32'(m_keep), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    #1 chk("rel_sready", 32'(s_ready), 32'd1);

    // two-beat packet
    beat(16'hBEEF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_half_valid", 32'(m_valid), 32'd0);
    beat(16'hDEAD, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t1_valid", 32'(m_valid), 32'd1);
    chk("t1_data", m_data, 32'hDEADBEEF);
    chk("t1_keep", 32'(m_keep), 32'hF);
    chk("t1_last", 32'(m_last), 32'd1);
    @(negedge clk);
    chk("t1_consumed", 32'(m_valid), 32'd0);

    // short packet
    beat(16'h1234, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_data", m_data, 32'h00001234);
    chk("t2_keep", 32'(m_keep), 32'h3);
    chk("t2_last", 32'(m_last), 32'd1);
    @(negedge clk);

    // continuous 8-beat stream
    vcnt = 0; rdy_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      vcnt += int'(m_valid);
      rdy_ok &= s_ready;
      beat(16'h1000 + 16'(i), 2'b11, (i == 7), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    vcnt += int'(m_valid);
    chk("t3_sready_steady", 32'(rdy_ok), 32'd1);
    chk("t3_beats", 32'(vcnt), 32'd4);
    chk("t3_last_data", m_data, 32'h10071006);
    chk("t3_last_flag", 32'(m_last), 32'd1);
    @(negedge clk);
    chk("t3_drained", 32'(m_valid), 32'd0);

    // backpressure
    m_ready = 1'b0;
    beat(16'hAAAA, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    beat(16'hBBBB, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    beat(16'hCCCC, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("t4_sready_blk", 32'(s_ready), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(m_valid), 32'd1);
      chk("t4_hold_data", m_data, 32'hBBBBAAAA);
      chk("t4_hold_last", 32'(m_last), 32'd0);
      chk("t4_hold_sready", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("t4_once", 32'(m_valid), 32'd0);

    // reset mid-packet
    beat(16'h1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_data", m_data, 32'd0);
    chk("t5_keep", 32'(m_keep), 32'd0);
    chk("t5_sready", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    beat(16'h2222, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_no_output", 32'(m_valid), 32'd0);
    beat(16'h3333, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t5_post_valid", 32'(m_valid), 32'd1);
    chk("t5_post_data", m_data, 32'h33332222);
    chk("t5_post_keep", 32'(m_keep), 32'hF);
    @(negedge clk);

`ifdef AXIS_UPSIZE_ID_FLUSH_EN
    // tid change flushes the partial word
    beat(16'h5555, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    beat(16'h6666, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("t6_sready_flush", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("t6_fl_valid", 32'(m_valid), 32'd1);
    chk("t6_fl_data", m_data, 32'h00005555);
    chk("t6_fl_keep", 32'(m_keep), 32'h3);
    chk("t6_fl_last", 32'(m_last), 32'd0);
    chk("t6_fl_tid", 32'(m_id), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t6_nw_valid", 32'(m_valid), 32'd1);
    chk("t6_nw_data", m_data, 32'h00006666);
    chk("t6_nw_keep", 32'(m_keep), 32'h3);
    chk("t6_nw_last", 32'(m_last), 32'd1);
    chk("t6_nw_tid", 32'(m_id), 32'd1);
`else
    // sideband: final tid/tdest win, tuser ORs
    beat(16'h5555, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    beat(16'h6666, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t6_valid", 32'(m_valid), 32'd1);
    chk("t6_data", m_data, 32'h66665555);
    chk("t6_tid", 32'(m_id), 32'd1);
    chk("t6_tdest", 32'(m_dest), 32'd1);
    chk("t6_tuser", 32'(m_user), 32'd1);
    chk("t6_last", 32'(m_last), 32'd1);
`endif
    @(negedge clk);
    chk("end_idle", 32'(m_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
